ara_wdump_buffer: RTL and testbench

ARA_WDUMP_BUFFER -- requirements
Module: ara_wdump_buffer

---
 rtl/ara_wdump_buffer.sv | 131 +++++++++++++
 tb/tb_ara_wdump_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ara_wdump_buffer.sv
// ara_wdump_buffer
//   Passive tap on the VLSU AXI W channel. Beats that handshake while the dump
//   is enabled are queued in a small FIFO, then serialised one strobed byte per
//   cycle (lowest enabled byte lane first) to a byte consumer. Beats arriving
//   while the FIFO is full are dropped and counted.
// Ports
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   en_i               : dump enable (gates capture only, draining continues)
//   w_data_i/w_strb_i  : W data and strobe tap
//   w_valid_i/w_ready_i: observed W handshake (never driven by this block)
//   byte_o/byte_valid_o/byte_ready_i : byte stream to the consumer
//   bytes_cnt_o        : total bytes emitted (wraps)
//   drop_cnt_o         : beats dropped on overflow (saturates)
//   overflow_o         : sticky overflow flag
//   empty_o            : FIFO empty
module ara_wdump_buffer #(
  parameter int DataWidth = 256,
  parameter int BeWidth   = DataWidth / 8,
  parameter int Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [DataWidth-1:0] w_data_i,
  input  logic [BeWidth-1:0]   w_strb_i,
  input  logic                 w_valid_i,
  input  logic                 w_ready_i,
  output logic [7:0]           byte_o,
  output logic                 byte_valid_o,
  input  logic                 byte_ready_i,
  output logic [31:0]          bytes_cnt_o,
  output logic [31:0]          drop_cnt_o,
  output logic                 overflow_o,
  output logic                 empty_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int IdxW = $clog2(BeWidth);

  logic [DataWidth-1:0] data_q [Depth];
  logic [BeWidth-1:0]   strb_q [Depth];

  logic [PtrW:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]    bytes_cnt_q, bytes_cnt_d;
  logic [31:0]    drop_cnt_q, drop_cnt_d;
  logic           overflow_q, overflow_d;

  logic [PtrW-1:0]      wr_idx, rd_idx;
  logic                 empty, full;
  logic                 capture, push, drop, consume, pop;
  logic [DataWidth-1:0] head_data;
  logic [BeWidth-1:0]   head_strb, head_strb_clr;
  logic [IdxW-1:0]      lsb_idx;

  assign wr_idx    = wr_ptr_q[PtrW-1:0];
  assign rd_idx    = rd_ptr_q[PtrW-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign head_data = data_q[rd_idx];
  assign head_strb = strb_q[rd_idx];

  // Lowest set strobe bit of the head entry selects the next byte lane.
  always_comb begin
    lsb_idx = '0;
    for (int unsigned i = BeWidth; i > 0; i--) begin
      if (head_strb[i-1]) lsb_idx = IdxW'(i - 1);
    end
  end

  assign head_strb_clr = head_strb & ~(BeWidth'(1) << lsb_idx);

  // Fullness is judged on start-of-cycle occupancy, so a same-cycle pop
  // does not make room for a capture that arrives while full.
  assign capture = w_valid_i && w_ready_i && en_i && (w_strb_i != '0);
  assign push    = capture && !full;
  assign drop    = capture && full;
  assign consume = !empty && byte_ready_i;
  assign pop     = consume && (head_strb_clr == '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    bytes_cnt_d = bytes_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
    if (consume) bytes_cnt_d = bytes_cnt_q + 32'd1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      bytes_cnt_q <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      bytes_cnt_q <= bytes_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Payload storage needs no reset: entries are only visible between the
  // pointers. Push and head update never alias, since wr_idx == rd_idx only
  // when empty (no consume) or full (no push).
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_idx] <= w_data_i;
      strb_q[wr_idx] <= w_strb_i;
    end
    if (consume && !pop) strb_q[rd_idx] <= head_strb_clr;
  end

  assign byte_valid_o = !empty;
  assign empty_o      = empty;
  assign byte_o       = empty ? 8'h00 : head_data[{lsb_idx, 3'b000} +: 8];
  assign bytes_cnt_o  = bytes_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ara_wdump_buffer.sv
module tb_ara_wdump_buffer;

  localparam int DW    = 64;
  localparam int BW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0;
  logic [DW-1:0] w_data_i = '0;
  logic [BW-1:0] w_strb_i = '0;
  logic          w_valid_i = 1'b0;
  logic          w_ready_i = 1'b0;
  logic [7:0]    byte_o;
  logic          byte_valid_o;
  logic          byte_ready_i = 1'b0;
  logic [31:0]   bytes_cnt_o;
  logic [31:0]   drop_cnt_o;
  logic          overflow_o;
  logic          empty_o;

  ara_wdump_buffer #(
    .DataWidth(DW),
    .BeWidth  (BW),
    .Depth    (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .w_data_i    (w_data_i),
    .w_strb_i    (w_strb_i),
    .w_valid_i   (w_valid_i),
    .w_ready_i   (w_ready_i),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i),
    .bytes_cnt_o (bytes_cnt_o),
    .drop_cnt_o  (drop_cnt_o),
    .overflow_o  (overflow_o),
    .empty_o     (empty_o)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending beats with their remaining strobes.
  typedef struct {
    logic [DW-1:0] data;
    logic [BW-1:0] strb;
  } beat_t;

  beat_t       mq[$];
  int unsigned m_bytes;
  int unsigned m_drop;
  logic        m_ovf;

  int unsigned n_checks;
  int unsigned n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_lane(input logic [BW-1:0] s);
    for (int i = 0; i < BW; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] head_byte(input beat_t b);
    int l;
    l = first_lane(b.strb);
    if (l < 0) return 8'h00;
    return b.data[l*8 +: 8];
  endfunction

  task automatic check_outputs();
    check_eq("byte_valid", byte_valid_o, (mq.size() != 0));
    check_eq("empty", empty_o, (mq.size() == 0));
    if (mq.size() != 0) check_eq("byte", byte_o, head_byte(mq[0]));
    check_eq("bytes_cnt", bytes_cnt_o, m_bytes);
    check_eq("drop_cnt", drop_cnt_o, m_drop);
    check_eq("overflow", overflow_o, m_ovf);
  endtask

  task automatic model_step();
    int    occ;
    bit    cap;
    beat_t h;
    int    l;
    occ = mq.size();
    cap = w_valid_i && w_ready_i && en_i && (w_strb_i != 0);
    if (occ != 0 && byte_ready_i) begin
      h = mq[0];
      l = first_lane(h.strb);
      h.strb[l] = 1'b0;
      m_bytes++;
      if (h.strb == 0) void'(mq.pop_front());
      else mq[0] = h;
    end
    if (cap) begin
      if (occ == DEPTH) begin
        if (m_drop != 32'hFFFF_FFFF) m_drop++;
        m_ovf = 1'b1;
      end else begin
        mq.push_back('{data: w_data_i, strb: w_strb_i});
      end
    end
  endtask

  // One clock: check outputs mid-cycle, advance model, step past the edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic e,
                       input logic [DW-1:0] d, input logic [BW-1:0] s);
    w_valid_i = v;
    w_ready_i = r;
    en_i      = e;
    w_data_i  = d;
    w_strb_i  = s;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    check_eq("rst_byte_valid", byte_valid_o, 1'b0);
    check_eq("rst_byte", byte_o, 8'h00);
    check_eq("rst_empty", empty_o, 1'b1);
    check_eq("rst_bytes_cnt", bytes_cnt_o, 32'd0);
    check_eq("rst_drop_cnt", drop_cnt_o, 32'd0);
    check_eq("rst_overflow", overflow_o, 1'b0);
    mq.delete();
    m_bytes = 0;
    m_drop  = 0;
    m_ovf   = 1'b0;
    idle();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] d;
    n_checks = 0;
    n_fail   = 0;
    #2;
    do_reset();

    // Two-byte beat, strobe 0x81: lanes 0 then 7.
    byte_ready_i = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 64'h1122334455667788, 8'h81);
    tick();
    idle();
    check_eq("r032_b0", byte_o, 8'h88);
    tick();
    check_eq("r032_b1", byte_o, 8'h11);
    tick();
    check_eq("r032_cnt", bytes_cnt_o, 32'd2);
    check_eq("r032_empty", empty_o, 1'b1);

    // Null strobe and missing ready never capture.
    drive(1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0002, 8'hFF);
    tick();
    idle();
    check_eq("r033_valid", byte_valid_o, 1'b0);
    tick();

    // Enable gating, then full-beat lane order.
    drive(1'b1, 1'b1, 1'b0, 64'h1122334455667788, 8'hFF);
    tick();
    check_eq("r034_nocap", byte_valid_o, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 64'h1122334455667788, 8'hFF);
    tick();
    idle();
    check_eq("r034_first", byte_o, 8'h88);
    repeat (9) tick();

    // Overflow: five beats into a four-deep FIFO with the consumer stalled.
    do_reset();
    byte_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom};
      drive(1'b1, 1'b1, 1'b1, d, 8'hFF);
      tick();
    end
    idle();
    tick();
    check_eq("r035_drop", drop_cnt_o, 32'd1);
    check_eq("r035_ovf", overflow_o, 1'b1);
    byte_ready_i = 1'b1;
    repeat (34) tick();
    check_eq("r035_bytes", bytes_cnt_o, 32'd32);
    check_eq("r035_ovf_sticky", overflow_o, 1'b1);
    check_eq("r035_empty", empty_o, 1'b1);

    // Full with head on its last byte: same-cycle pop does not admit a capture.
    do_reset();
    byte_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      drive(1'b1, 1'b1, 1'b1, d, 8'h01);
      tick();
    end
    byte_ready_i = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 64'hCAFE_F00D_1234_5678, 8'h01);
    tick();
    idle();
    check_eq("r036_drop", drop_cnt_o, 32'd1);
    check_eq("r036_ovf", overflow_o, 1'b1);
    repeat (5) tick();
    check_eq("r036_bytes", bytes_cnt_o, 32'd4);

    // Reset mid-drain discards the remaining bytes.
    do_reset();
    byte_ready_i = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 64'h0102030405060708, 8'hFF);
    tick();
    idle();
    repeat (3) tick();
    check_eq("r037_mid_cnt", bytes_cnt_o, 32'd3);
    #2;
    do_reset();
    repeat (10) tick();
    check_eq("r037_after_cnt", bytes_cnt_o, 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      d = {$urandom, $urandom};
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) != 0), d,
            ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
      byte_ready_i = ($urandom_range(0, 9) < 6);
      tick();
    end
    idle();
    byte_ready_i = 1'b1;
    repeat (40) tick();
    check_eq("rand_drained", empty_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
